forth_sequencer: RTL and testbench

//   Control sequencer for the Forth RNS datapath (operand stack + RNS ALU).

---
 rtl/forth_sequencer.sv | 179 +++++++++++++++++
 tb/tb_forth_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/forth_sequencer.sv
// Command sequencer for the Forth RNS datapath: validates stack depth per command,
// then walks READ/EXEC/WB to drive stack strobes and the ALU opcode.
module forth_sequencer #(
  parameter int DEPTH   = 127,
  parameter int ALU_LAT = 2,
  localparam int DW     = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [3:0]    cmd_i,
  input  logic [15:0]   cmd_imm_i,
  input  logic [15:0]   stk_op1_i,
  input  logic [15:0]   stk_op2_i,
  input  logic [15:0]   alu_result_i,
  output logic          stk_read_o,
  output logic          stk_write_o,
  output logic [15:0]   stk_data_o,
  output logic [1:0]    alu_op_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [DW-1:0] depth_o,
  output logic [2:0]    state_o,
  output logic [31:0]   dbg_ops_o
);

  localparam int WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [3:0] CMD_NOP  = 4'd0;
  localparam logic [3:0] CMD_PUSH = 4'd1;
  localparam logic [3:0] CMD_POP  = 4'd2;
  localparam logic [3:0] CMD_ADD  = 4'd3;
  localparam logic [3:0] CMD_MUL  = 4'd4;
  localparam logic [3:0] CMD_DUP  = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state_q;
  logic          cmd_ready_q;
  logic          stk_read_q;
  logic          stk_write_q;
  logic [15:0]   stk_data_q;
  logic [1:0]    alu_op_q;
  logic          done_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic [DW-1:0] depth_q;
  logic [WW-1:0] wait_q;
  logic [3:0]    op_q;
  logic [31:0]   dbg_ops_q;

  logic [1:0]    chk_code_d;
  logic          full_d;
  logic          handshake_d;

  assign full_d      = (depth_q == DW'(DEPTH));
  assign handshake_d = cmd_valid_i & cmd_ready_q;

  // Illegal beats underflow beats overflow; 0 means the command may issue.
  always_comb begin
    chk_code_d = 2'd0;
    case (cmd_i)
      CMD_NOP:          chk_code_d = 2'd0;
      CMD_PUSH:         if (full_d) chk_code_d = 2'd2;
      CMD_POP:          if (depth_q == '0) chk_code_d = 2'd1;
      CMD_ADD, CMD_MUL: if (depth_q <= DW'(1)) chk_code_d = 2'd1;
      CMD_DUP: begin
        if (depth_q == '0) chk_code_d = 2'd1;
        else if (full_d)   chk_code_d = 2'd2;
      end
      default:          chk_code_d = 2'd3;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      stk_read_q  <= 1'b0;
      stk_write_q <= 1'b0;
      stk_data_q  <= '0;
      alu_op_q    <= 2'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      depth_q     <= '0;
      wait_q      <= '0;
      op_q        <= CMD_NOP;
      dbg_ops_q   <= '0;
    end else begin
      done_q      <= 1'b0;
      stk_read_q  <= 1'b0;
      stk_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (handshake_d) begin
            op_q <= cmd_i;
            if (chk_code_d != 2'd0) begin
              state_q     <= S_ERR;
              cmd_ready_q <= 1'b0;
              err_q       <= 1'b1;
              err_code_q  <= chk_code_d;
            end else begin
              case (cmd_i)
                CMD_PUSH: begin
                  state_q     <= S_WB;
                  cmd_ready_q <= 1'b0;
                  stk_write_q <= 1'b1;
                  stk_data_q  <= cmd_imm_i;
                  done_q      <= 1'b1;
                end
                CMD_POP: begin
                  state_q     <= S_WB;
                  cmd_ready_q <= 1'b0;
                  stk_read_q  <= 1'b1;
                  done_q      <= 1'b1;
                end
                CMD_ADD, CMD_MUL, CMD_DUP: begin
                  state_q     <= S_READ;
                  cmd_ready_q <= 1'b0;
                  alu_op_q    <= (cmd_i == CMD_ADD) ? 2'd1 :
                                 (cmd_i == CMD_MUL) ? 2'd2 : 2'd3;
                end
                default: done_q <= 1'b1;  // NOP retires in place
              endcase
            end
          end
        end
        S_READ: begin
          state_q   <= S_EXEC;
          wait_q    <= WW'(ALU_LAT - 1);
          dbg_ops_q <= {stk_op2_i, stk_op1_i};
        end
        S_EXEC: begin
          if (wait_q == '0) begin
            state_q     <= S_WB;
            stk_write_q <= 1'b1;
            stk_read_q  <= (alu_op_q != 2'd3);
            stk_data_q  <= alu_result_i;
            done_q      <= 1'b1;
          end else begin
            wait_q <= wait_q - WW'(1);
          end
        end
        S_WB: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          alu_op_q    <= 2'd0;
          if (op_q == CMD_PUSH || op_q == CMD_DUP) depth_q <= depth_q + DW'(1);
          else                                     depth_q <= depth_q - DW'(1);
        end
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked by rst so an abandoned command never reaches the stack.
  assign stk_read_o  = stk_read_q & ~rst_i;
  assign stk_write_o = stk_write_q & ~rst_i;
  assign done_o      = done_q & ~rst_i;
  assign cmd_ready_o = cmd_ready_q;
  assign stk_data_o  = stk_data_q;
  assign alu_op_o    = alu_op_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign depth_o     = depth_q;
  assign state_o     = state_q;
  assign dbg_ops_o   = dbg_ops_q;

endmodule

// File: tb/tb_forth_sequencer.sv
// Directed bench for forth_sequencer with a small stack memory and ALU model.
module tb_forth_sequencer;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;
  localparam int DW      = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [3:0]    cmd_i = '0;
  logic [15:0]   cmd_imm_i = '0;
  logic [15:0]   stk_op1_i = '0;
  logic [15:0]   stk_op2_i = '0;
  logic [15:0]   alu_result_i;
  logic          stk_read_o;
  logic          stk_write_o;
  logic [15:0]   stk_data_o;
  logic [1:0]    alu_op_o;
  logic          done_o;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic [DW-1:0] depth_o;
  logic [2:0]    state_o;
  logic [31:0]   dbg_ops_o;

  int n_cmp = 0;
  int n_mis = 0;

  forth_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_i(cmd_i), .cmd_imm_i(cmd_imm_i), .stk_op1_i(stk_op1_i), .stk_op2_i(stk_op2_i),
    .alu_result_i(alu_result_i), .stk_read_o(stk_read_o), .stk_write_o(stk_write_o),
    .stk_data_o(stk_data_o), .alu_op_o(alu_op_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .depth_o(depth_o), .state_o(state_o), .dbg_ops_o(dbg_ops_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // stack memory with registered top / top-1 read
  logic [15:0] stk_mem [0:7];
  int sp = 0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      sp <= 0;
    end else if (stk_read_o && stk_write_o) begin
      stk_mem[(sp - 2) & 7] <= stk_data_o;
      sp <= sp - 1;
    end else if (stk_write_o) begin
      stk_mem[sp & 7] <= stk_data_o;
      sp <= sp + 1;
    end else if (stk_read_o) begin
      sp <= sp - 1;
    end
    stk_op1_i <= (sp >= 1) ? stk_mem[(sp - 1) & 7] : 16'd0;
    stk_op2_i <= (sp >= 2) ? stk_mem[(sp - 2) & 7] : 16'd0;
  end

  always_comb begin
    alu_result_i = 16'd0;
    case (alu_op_o)
      2'd1:    alu_result_i = stk_op1_i + stk_op2_i;
      2'd2:    alu_result_i = stk_op1_i * stk_op2_i;
      2'd3:    alu_result_i = stk_op1_i;
      default: alu_result_i = 16'd0;
    endcase
  end

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks (all called and returning at a negedge)
  task automatic do_reset();
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  // Returns in cycle T+1 (the half-cycle after the handshake edge).
  task automatic issue(input logic [3:0] c, input logic [15:0] imm);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_i = c;
    cmd_imm_i = imm;
    while (!cmd_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!cmd_ready_o) check_eq("ready_timeout", 32'(cmd_ready_o), 32'd1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_i = 4'($urandom_range(0, 15));
    cmd_imm_i = 16'($urandom_range(0, 65535));
  endtask

  initial begin
    // Test 1: reset, PUSH 5, PUSH 7, ADD
    do_reset();
    check_eq("rst_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_depth", 32'(depth_o), 32'd0);
    check_eq("rst_err", {28'd0, err_o, err_code_o, done_o}, 32'd0);
    check_eq("rst_strobes", {29'd0, stk_read_o, stk_write_o, 1'b0}, 32'd0);
    check_eq("rst_alu_data", {14'd0, alu_op_o, stk_data_o}, 32'd0);

    issue(4'd1, 16'd5);
    check_eq("push5_wb", {29'd0, stk_read_o, stk_write_o, done_o}, 32'b011);
    check_eq("push5_data", 32'(stk_data_o), 32'd5);
    check_eq("push5_ready_wb", 32'(cmd_ready_o), 32'd0);
    step(1);
    check_eq("push5_depth", 32'(depth_o), 32'd1);
    check_eq("push5_done_clr", 32'(done_o), 32'd0);
    issue(4'd1, 16'd7);
    step(1);
    check_eq("push7_depth", 32'(depth_o), 32'd2);

    issue(4'd3, 16'd0);
    check_eq("add_read_state", 32'(state_o), 32'd1);
    check_eq("add_read_aluop", 32'(alu_op_o), 32'd1);
    check_eq("add_read_strobes", {30'd0, stk_read_o, stk_write_o}, 32'd0);
    step(1);
    check_eq("add_exec_state", 32'(state_o), 32'd2);
    check_eq("add_exec_aluop", 32'(alu_op_o), 32'd1);
    check_eq("add_ops", dbg_ops_o, 32'h0005_0007);
    step(1);
    check_eq("add_exec2_strobes", {29'd0, stk_read_o, stk_write_o, done_o}, 32'd0);
    step(1);
    check_eq("add_wb_strobes", {29'd0, stk_read_o, stk_write_o, done_o}, 32'b111);
    check_eq("add_wb_data", 32'(stk_data_o), 32'd12);
    check_eq("add_wb_aluop", 32'(alu_op_o), 32'd1);
    step(1);
    check_eq("add_depth", 32'(depth_o), 32'd1);
    check_eq("add_idle_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("add_idle_aluop", 32'(alu_op_o), 32'd0);

    // NOP retires in place
    issue(4'd0, 16'd0);
    check_eq("nop_done", {29'd0, done_o, stk_read_o, stk_write_o}, 32'b100);
    check_eq("nop_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("nop_depth", 32'(depth_o), 32'd1);

    // POP
    issue(4'd2, 16'd0);
    check_eq("pop_wb", {29'd0, stk_read_o, stk_write_o, done_o}, 32'b101);
    step(1);
    check_eq("pop_depth", 32'(depth_o), 32'd0);

    // Test 2: PUSH 3, DUP, MUL
    do_reset();
    issue(4'd1, 16'd3);
    step(1);
    issue(4'd5, 16'd0);
    step(1);
    check_eq("dup_exec_aluop", 32'(alu_op_o), 32'd3);
    step(2);
    check_eq("dup_wb", {29'd0, stk_read_o, stk_write_o, done_o}, 32'b011);
    check_eq("dup_wb_data", 32'(stk_data_o), 32'd3);
    step(1);
    check_eq("dup_depth", 32'(depth_o), 32'd2);
    issue(4'd4, 16'd0);
    step(1);
    check_eq("mul_exec_aluop", 32'(alu_op_o), 32'd2);
    step(2);
    check_eq("mul_wb", {29'd0, stk_read_o, stk_write_o, done_o}, 32'b111);
    check_eq("mul_wb_data", 32'(stk_data_o), 32'd9);
    step(1);
    check_eq("mul_depth", 32'(depth_o), 32'd1);

    // Test 3: ADD on empty stack -> underflow, sticky
    do_reset();
    issue(4'd3, 16'd0);
    check_eq("uf_err", {29'd0, err_o, err_code_o}, 32'b101);
    check_eq("uf_state", 32'(state_o), 32'd4);
    check_eq("uf_ready", 32'(cmd_ready_o), 32'd0);
    cmd_valid_i = 1'b1;
    cmd_i = 4'd1;
    cmd_imm_i = 16'd99;
    for (int i = 0; i < 3; i++) begin
      check_eq("uf_no_strobe", {29'd0, stk_read_o, stk_write_o, done_o}, 32'd0);
      step(1);
    end
    cmd_valid_i = 1'b0;
    check_eq("uf_still_ready0", 32'(cmd_ready_o), 32'd0);
    check_eq("uf_sticky", {29'd0, err_o, err_code_o}, 32'b101);
    check_eq("uf_depth", 32'(depth_o), 32'd0);

    // Test 4: overflow on PUSH and DUP at DEPTH=4
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(4'd1, 16'(i + 10));
      step(1);
    end
    check_eq("full_depth", 32'(depth_o), 32'd4);
    issue(4'd1, 16'd77);
    check_eq("of_push_err", {29'd0, err_o, err_code_o}, 32'b110);
    check_eq("of_push_nowrite", 32'(stk_write_o), 32'd0);
    step(1);
    check_eq("of_push_depth", 32'(depth_o), 32'd4);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(4'd1, 16'(i + 20));
      step(1);
    end
    issue(4'd5, 16'd0);
    check_eq("of_dup_err", {29'd0, err_o, err_code_o}, 32'b110);
    check_eq("of_dup_aluop", 32'(alu_op_o), 32'd0);

    // Test 5: illegal opcode beats underflow
    do_reset();
    check_eq("rst_clears_err", {29'd0, err_o, err_code_o}, 32'd0);
    issue(4'd9, 16'd0);
    check_eq("ill_err", {29'd0, err_o, err_code_o}, 32'b111);

    // Test 6: back-to-back PUSH with valid held, then rst during ADD EXEC
    do_reset();
    cmd_valid_i = 1'b1;
    cmd_i = 4'd1;
    for (int k = 0; k < 3; k++) begin
      cmd_imm_i = 16'(k + 1);
      check_eq("b2b_ready", 32'(cmd_ready_o), 32'd1);
      step(1);
      check_eq("b2b_write", {30'd0, stk_write_o, cmd_ready_o}, 32'b10);
      check_eq("b2b_data", 32'(stk_data_o), 32'(k + 1));
      step(1);
    end
    cmd_valid_i = 1'b0;
    check_eq("b2b_depth", 32'(depth_o), 32'd3);
    issue(4'd3, 16'd0);
    step(1);
    check_eq("rst_mid_exec", 32'(state_o), 32'd2);
    rst_i = 1'b1;
    step(1);
    check_eq("rst_mid_strobes", {29'd0, stk_read_o, stk_write_o, done_o}, 32'd0);
    check_eq("rst_mid_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("rst_mid_depth", 32'(depth_o), 32'd0);
    rst_i = 1'b0;
    step(1);
    check_eq("rst_after_strobes", {29'd0, stk_read_o, stk_write_o, done_o}, 32'd0);
    check_eq("rst_after_state", 32'(state_o), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
